// File: rtl/edge_pulse_pkg.sv
// Shared mode encodings and a constant width helper for the edge pulse generator.
// Pure definitions: no logic, no latency, no flow control.
package edge_pulse_pkg;

    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/edge_pulse_chan.sv
// One channel: synchroniser, optional debounce (EDGE_DEBOUNCE_EN), edge detect, stretch, sticky flag.
// Pulse follows a sampled input change by SYNC_STAGES(+DEB_CYCLES)+1 cycles; no backpressure.
module edge_pulse_chan
    import edge_pulse_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1
`ifdef EDGE_DEBOUNCE_EN
    ,
    parameter int DEB_CYCLES  = 4
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       armed,
    input  logic       sig,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       level,
    output logic       pulse,
    output logic       flag
);

    localparam int CW = clog2(PULSE_LEN + 1);

    logic          s;
    logic          d;
    logic          h;
    logic          rise;
    logic          fall;
    logic          edge_det;
    logic [CW-1:0] cnt;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = sig;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= sig;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

`ifdef EDGE_DEBOUNCE_EN
    localparam int DW = clog2(DEB_CYCLES + 1);

    logic [DW-1:0] deb_cnt;
    logic          d_q;

    // d only follows s once s has differed from it for DEB_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q     <= 1'b0;
            deb_cnt <= '0;
        end else if (s != d_q) begin
            if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
                d_q     <= s;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    assign d = d_q;
`else
    assign d = s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            h <= 1'b0;
        end else begin
            h <= d;
        end
    end

    assign rise = d & ~h;
    assign fall = ~d & h;

    always_comb begin
        edge_det = 1'b0;
        case (mode)
            EDGE_OFF:  edge_det = 1'b0;
            EDGE_RISE: edge_det = rise;
            EDGE_FALL: edge_det = fall;
            EDGE_BOTH: edge_det = rise | fall;
        endcase
        edge_det = edge_det & armed;
    end

    // pulse is kept as its own flop, equal to (cnt != 0), so the output is glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            if (edge_det) begin
                cnt <= CW'(PULSE_LEN);
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            pulse <= edge_det | (cnt > CW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag <= 1'b0;
        end else if (edge_det) begin
            flag <= 1'b1;
        end else if (clr) begin
            flag <= 1'b0;
        end
    end

    assign level = d;

endmodule

// File: rtl/edge_pulse_gen.sv
// Multi-channel edge-to-pulse generator with shared post-reset arming; EDGE_DEBOUNCE_EN adds debounce.
// Pulse latency SYNC_STAGES(+DEB_CYCLES)+1 cycles; no backpressure, every edge is captured.
module edge_pulse_gen
    import edge_pulse_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1,
    parameter int DEB_CYCLES  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH-1:0]     sig,
    input  logic [2*N_CH-1:0]   mode,
    input  logic [N_CH-1:0]     clr,
    output logic [N_CH-1:0]     level,
    output logic [N_CH-1:0]     pulse,
    output logic [N_CH-1:0]     flag
);

`ifdef EDGE_DEBOUNCE_EN
    localparam bit DEB_EN = 1'b1;
`else
    localparam bit DEB_EN = 1'b0;
`endif

    // Long enough for the reset-zeroed pipeline to fill, hiding inputs already high at reset.
    localparam int ARM_LEN = SYNC_STAGES + 1 + (DEB_EN ? DEB_CYCLES : 0);
    localparam int AW      = clog2(ARM_LEN + 1);

    logic [AW-1:0] arm_cnt;
    logic          armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            arm_cnt <= '0;
        end else if (arm_cnt != AW'(ARM_LEN)) begin
            arm_cnt <= arm_cnt + AW'(1);
        end
    end

    assign armed = (arm_cnt == AW'(ARM_LEN));

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            edge_pulse_chan #(
                .SYNC_STAGES (SYNC_STAGES),
                .PULSE_LEN   (PULSE_LEN)
`ifdef EDGE_DEBOUNCE_EN
                ,
                .DEB_CYCLES  (DEB_CYCLES)
`endif
            ) u_chan (
                .clk   (clk),
                .rst   (rst),
                .armed (armed),
                .sig   (sig[i]),
                .mode  (mode[2*i +: 2]),
                .clr   (clr[i]),
                .level (level[i]),
                .pulse (pulse[i]),
                .flag  (flag[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Bench for edge_pulse_gen: three instances (PULSE_LEN 1, 3, 4) share stimulus;
// expectations are queued with their due cycle and compared on the falling edge.
module tb_edge_pulse_gen;

`ifdef EDGE_DEBOUNCE_EN
    localparam int DEB = 4;
`else
    localparam int DEB = 0;
`endif
    localparam int SYNC = 2;
    localparam int L    = SYNC + DEB;
    localparam int P    = L + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sig;
    logic [7:0] mode;
    logic [3:0] clr;
    logic [3:0] level_o [3];
    logic [3:0] pulse_o [3];
    logic [3:0] flag_o  [3];

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         cyc;
        int         inst;
        int         sel;
        logic [3:0] val;
        string      tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    edge_pulse_gen #(.N_CH(4), .SYNC_STAGES(SYNC), .PULSE_LEN(1), .DEB_CYCLES(4)) u_p1 (
        .clk(clk), .rst(rst), .sig(sig), .mode(mode), .clr(clr),
        .level(level_o[0]), .pulse(pulse_o[0]), .flag(flag_o[0]));
    edge_pulse_gen #(.N_CH(4), .SYNC_STAGES(SYNC), .PULSE_LEN(3), .DEB_CYCLES(4)) u_p3 (
        .clk(clk), .rst(rst), .sig(sig), .mode(mode), .clr(clr),
        .level(level_o[1]), .pulse(pulse_o[1]), .flag(flag_o[1]));
    edge_pulse_gen #(.N_CH(4), .SYNC_STAGES(SYNC), .PULSE_LEN(4), .DEB_CYCLES(4)) u_p4 (
        .clk(clk), .rst(rst), .sig(sig), .mode(mode), .clr(clr),
        .level(level_o[2]), .pulse(pulse_o[2]), .flag(flag_o[2]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // sel: 0 = pulse, 1 = flag, 2 = level
    task automatic expect_at(input int c, input int inst, input int sel,
                             input logic [3:0] v, input string tag);
        exp_t e;
        e.cyc  = c;
        e.inst = inst;
        e.sel  = sel;
        e.val  = v;
        e.tag  = $sformatf("%s_i%0d@%0d", tag, inst, c);
        sb.push_back(e);
    endtask

    function automatic logic [3:0] get_out(input int inst, input int sel);
        case (sel)
            0:       return pulse_o[inst];
            1:       return flag_o[inst];
            default: return level_o[inst];
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check_eq(sb[i].tag, 32'(get_out(sb[i].inst, sb[i].sel)), 32'(sb[i].val));
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                check_eq({sb[i].tag, "_stale"}, cyc, sb[i].cyc);
                sb.delete(i);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_flags();
        clr = 4'hF;
        tick(1);
        clr = 4'h0;
    endtask

    initial begin
        int k;
        int r;
        int st;
        logic [3:0] v;

        rst  = 1'b1;
        sig  = 4'hF;
        mode = 8'hFF;
        clr  = 4'h0;

        // reset state, with inputs held high through reset
        tick(3);
        for (int i = 0; i < 3; i++) begin
            expect_at(cyc, i, 0, 4'h0, "rst_pulse");
            expect_at(cyc, i, 1, 4'h0, "rst_flag");
            expect_at(cyc, i, 2, 4'h0, "rst_level");
        end
        rst = 1'b0;
        r = cyc;
        // arming must hide the apparent rising edge of already-high inputs
        for (int c = 1; c <= P + 4; c++) begin
            for (int i = 0; i < 3; i++) begin
                expect_at(r + c, i, 0, 4'h0, "arm_pulse");
                expect_at(r + c, i, 1, 4'h0, "arm_flag");
            end
        end
        expect_at(r + L - 1, 0, 2, 4'h0, "arm_level_pre");
        expect_at(r + L, 0, 2, 4'hF, "arm_level");
        tick(P + 6);

        // mode 00: falling inputs produce nothing
        mode = 8'h00;
        tick(1);
        k = cyc;
        sig = 4'h0;
        expect_at(k + P, 0, 0, 4'h0, "off_pulse");
        expect_at(k + P + 1, 0, 1, 4'h0, "off_flag");
        expect_at(k + L, 0, 2, 4'h0, "off_level");
        tick(P + 4);

        // single rising edge on ch0, ch3 toggles but is off
        mode = 8'h15;
        tick(2);
        k = cyc;
        sig = 4'b1001;
        for (int c = P - 1; c <= P + 2; c++)
            expect_at(k + c, 0, 0, (c == P) ? 4'b0001 : 4'b0000, "t1_pulse");
        expect_at(k + P - 1, 0, 1, 4'b0000, "t1_flag_pre");
        expect_at(k + P, 0, 1, 4'b0001, "t1_flag");
        expect_at(k + P + 3, 0, 1, 4'b0001, "t1_flag_hold");
        expect_at(k + L - 1, 0, 2, 4'b0000, "t1_level_pre");
        expect_at(k + L, 0, 2, 4'b1001, "t1_level");
        tick(P + 6);
        k = cyc;
        sig = 4'h0;
        expect_at(k + P, 0, 0, 4'h0, "t1_nofall");
        expect_at(k + P + 1, 0, 0, 4'h0, "t1_nofall");
        tick(P + 3);
        clr = 4'hF;
        expect_at(cyc, 0, 1, 4'b0001, "t1_flag_b4clr");
        expect_at(cyc + 1, 0, 1, 4'b0000, "t1_flag_clr");
        tick(1);
        clr = 4'h0;

        // both edges, 10-cycle high on ch1, PULSE_LEN 3
        mode = 8'hFF;
        tick(1);
        k = cyc;
        sig = 4'b0010;
        for (int c = P - 1; c <= P + 13; c++) begin
            v = ((c >= P && c <= P + 2) || (c >= P + 10 && c <= P + 12)) ? 4'b0010 : 4'b0000;
            expect_at(k + c, 1, 0, v, "t2_pulse");
        end
        for (int c = L - 1; c <= L + 10; c++)
            expect_at(k + c, 1, 2, (c >= L && c <= L + 9) ? 4'b0010 : 4'b0000, "t2_level");
        tick(10);
        sig = 4'h0;
        tick(L + 8);
        clear_flags();

        // clr coincident with edge detect: set wins, next clr clears
        k = cyc;
        sig = 4'b0100;
        expect_at(k + L, 0, 1, 4'b0000, "t4_flag_pre");
        expect_at(k + P, 0, 0, 4'b0100, "t4_pulse");
        tick(L);
        clr = 4'b0100;
        expect_at(k + L + 1, 0, 1, 4'b0100, "t4_set_wins");
        tick(1);
        expect_at(k + L + 2, 0, 1, 4'b0000, "t4_clr_next");
        tick(1);
        clr = 4'h0;
        mode = 8'h00;
        tick(1);
        sig = 4'h0;
        tick(L + 4);

        // two rising edges two cycles apart merge into one pulse (PULSE_LEN 4)
        mode = 8'h55;
        tick(1);
        k = cyc;
        sig = 4'b1000;
        tick(1);
        sig = 4'b0000;
        tick(1);
        sig = 4'b1000;
        st = (DEB != 0) ? P + 2 : P;
        for (int c = P - 1; c <= P + 7; c++)
            expect_at(k + c, 2, 0, (c >= st && c <= P + 5) ? 4'b1000 : 4'b0000, "t5_pulse");
        tick(12);
        mode = 8'h00;
        tick(1);
        sig = 4'h0;
        tick(L + 4);
        clear_flags();

`ifdef EDGE_DEBOUNCE_EN
        // 3-cycle glitch is filtered; 4-cycle high passes
        mode = 8'h55;
        tick(1);
        k = cyc;
        sig = 4'b0001;
        for (int c = 0; c <= P + 6; c++)
            expect_at(k + c, 0, 0, 4'h0, "t6_glitch_pulse");
        expect_at(k + P + 6, 0, 1, 4'h0, "t6_glitch_flag");
        tick(3);
        sig = 4'h0;
        tick(P + 6);
        k = cyc;
        sig = 4'b0001;
        expect_at(k + P - 1, 0, 0, 4'b0000, "t6_pulse_pre");
        expect_at(k + P, 0, 0, 4'b0001, "t6_pulse");
        expect_at(k + P + 1, 0, 0, 4'b0000, "t6_pulse_post");
        tick(4);
        sig = 4'h0;
        tick(P + 8);
        clear_flags();
`else
        // 1-cycle glitch with both edges and PULSE_LEN 1 gives a 2-cycle pulse
        mode = 8'hFF;
        tick(1);
        k = cyc;
        sig = 4'b0001;
        tick(1);
        sig = 4'b0000;
        for (int c = P - 1; c <= P + 2; c++)
            expect_at(k + c, 0, 0, (c == P || c == P + 1) ? 4'b0001 : 4'b0000, "t6_glitch");
        tick(P + 4);
        clear_flags();
`endif

        // all channels at once
        mode = 8'hFF;
        tick(1);
        k = cyc;
        sig = 4'hF;
        expect_at(k + P - 1, 0, 0, 4'h0, "t7_pulse_pre");
        expect_at(k + P, 0, 0, 4'hF, "t7_pulse");
        expect_at(k + P, 0, 1, 4'hF, "t7_flag");
        tick(P + 3);

        // reset in the middle of a PULSE_LEN 4 pulse, input held high across it
        mode = 8'h55;
        tick(1);
        sig = 4'h0;
        tick(L + 4);
        clear_flags();
        k = cyc;
        sig = 4'b0001;
        expect_at(k + P, 2, 0, 4'b0001, "t8_pulse");
        tick(P + 1);
        rst = 1'b1;
        expect_at(k + P + 1, 2, 0, 4'b0001, "t8_pre_rst");
        expect_at(k + P + 2, 2, 0, 4'b0000, "t8_rst_drop");
        expect_at(k + P + 2, 2, 1, 4'b0000, "t8_rst_flag");
        tick(2);
        rst = 1'b0;
        r = cyc;
        for (int c = 1; c <= L + 4; c++) begin
            expect_at(r + c, 2, 0, 4'h0, "t8_rearm_pulse");
            expect_at(r + c, 2, 1, 4'h0, "t8_rearm_flag");
        end
        expect_at(r + L, 2, 2, 4'b0001, "t8_level");
        tick(L + 8);

        check_eq("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
